// File: rtl/visited_path_store.sv
// Multi-port visited/predecessor store with a traceback engine that streams the
// shortest path (target first, source last) over a valid/ready interface.
module visited_path_store #(
  parameter int MAX_NODES   = 16,
  parameter int INDEX_WIDTH = 5,
  parameter int WRITE_PORTS = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [INDEX_WIDTH-1:0]             number_of_nodes,
  input  logic [WRITE_PORTS-1:0]             set_en,
  input  logic [INDEX_WIDTH*WRITE_PORTS-1:0] set_index,
  input  logic [INDEX_WIDTH*WRITE_PORTS-1:0] set_prev,
  output logic [WRITE_PORTS-1:0]             set_reject,
  output logic [INDEX_WIDTH-1:0]             unvisited_nodes,
  output logic                               all_visited,
  output logic [INDEX_WIDTH*MAX_NODES-1:0]   prev_vector_flattened,
  input  logic                               trace_start,
  input  logic [INDEX_WIDTH-1:0]             trace_target,
  output logic                               trace_busy,
  output logic                               path_valid,
  input  logic                               path_ready,
  output logic [INDEX_WIDTH-1:0]             path_node,
  output logic                               path_last,
  output logic                               trace_fail
);

  localparam logic [INDEX_WIDTH-1:0] UNVISITED = {INDEX_WIDTH{1'b1}};
  localparam logic [INDEX_WIDTH:0]   MAX_LIMIT = (INDEX_WIDTH+1)'(MAX_NODES);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_EMIT = 1'b1} state_t;

  // Predecessor lookup that treats indices beyond the table as unvisited.
  function automatic logic [INDEX_WIDTH-1:0] f_lookup(
    input logic [INDEX_WIDTH*MAX_NODES-1:0] flat,
    input logic [INDEX_WIDTH-1:0]           idx
  );
    logic [INDEX_WIDTH-1:0] v;
    v = UNVISITED;
    for (int j = 0; j < MAX_NODES; j++) begin
      v = (idx == j[INDEX_WIDTH-1:0]) ? flat[INDEX_WIDTH*j +: INDEX_WIDTH] : v;
    end
    return v;
  endfunction

  logic [INDEX_WIDTH*MAX_NODES-1:0] r_prev_flat;
  logic [INDEX_WIDTH-1:0]           r_num_nodes;
  logic [INDEX_WIDTH-1:0]           r_unvisited;
  logic [WRITE_PORTS-1:0]           r_set_reject;
  state_t                           r_state;
  logic [INDEX_WIDTH-1:0]           r_cur;
  logic [INDEX_WIDTH-1:0]           r_steps;
  logic                             r_fail;

  logic [WRITE_PORTS-1:0]           w_en;
  logic [INDEX_WIDTH-1:0]           w_idx [WRITE_PORTS];
  logic [INDEX_WIDTH-1:0]           w_val [WRITE_PORTS];
  logic [WRITE_PORTS-1:0]           w_acc;
  logic [WRITE_PORTS-1:0]           w_rej;
  logic [INDEX_WIDTH-1:0]           w_acc_cnt;
  logic [INDEX_WIDTH*MAX_NODES-1:0] w_prev_flat_nxt;
  logic [INDEX_WIDTH-1:0]           w_unvisited_nxt;

  state_t                           w_state_nxt;
  logic [INDEX_WIDTH-1:0]           w_cur_nxt;
  logic [INDEX_WIDTH-1:0]           w_steps_nxt;
  logic                             w_fail_nxt;
  logic [INDEX_WIDTH-1:0]           w_prev_cur;
  logic [INDEX_WIDTH-1:0]           w_prev_nxt;
  logic [INDEX_WIDTH-1:0]           w_tgt_prev;
  logic                             w_tgt_ok;
  logic                             w_last;
  logic                             w_chain_end;

  // Unpack per-port fields; x/z enables are treated as idle.
  always_comb begin
    w_en = '0;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      w_en[p]  = (set_en[p] === 1'b1);
      w_idx[p] = set_index[INDEX_WIDTH*p +: INDEX_WIDTH];
      w_val[p] = set_prev[INDEX_WIDTH*p +: INDEX_WIDTH];
    end
  end

  // Write arbitration: lower-numbered port wins a same-index collision.
  always_comb begin : p_write
    logic l_dup;
    logic l_ok;
    w_acc           = '0;
    w_rej           = '0;
    w_acc_cnt       = '0;
    w_prev_flat_nxt = r_prev_flat;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      l_dup = 1'b0;
      for (int q = 0; q < p; q++) begin
        l_dup = l_dup | (w_en[q] && (w_idx[q] == w_idx[p]));
      end
      l_ok = w_en[p] && !l_dup
             && ({1'b0, w_idx[p]} < {1'b0, r_num_nodes})
             && ({1'b0, w_idx[p]} < MAX_LIMIT)
             && (f_lookup(r_prev_flat, w_idx[p]) == UNVISITED);
      w_acc[p]  = l_ok;
      w_rej[p]  = w_en[p] && !l_ok;
      w_acc_cnt = w_acc_cnt + INDEX_WIDTH'(l_ok);
      for (int j = 0; j < MAX_NODES; j++) begin
        w_prev_flat_nxt[INDEX_WIDTH*j +: INDEX_WIDTH] =
          (l_ok && (w_idx[p] == j[INDEX_WIDTH-1:0])) ? w_val[p]
                                                      : w_prev_flat_nxt[INDEX_WIDTH*j +: INDEX_WIDTH];
      end
    end
    w_unvisited_nxt = (r_unvisited >= w_acc_cnt) ? (r_unvisited - w_acc_cnt) : '0;
  end

  // Visited store, node count and reject pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_num_nodes  <= number_of_nodes;
      r_unvisited  <= number_of_nodes;
      r_prev_flat  <= '1;
      r_set_reject <= '0;
    end else begin
      r_num_nodes  <= r_num_nodes;
      r_unvisited  <= w_unvisited_nxt;
      r_prev_flat  <= w_prev_flat_nxt;
      r_set_reject <= w_rej;
    end
  end

  // Traceback next-state: the chain is read from the live (pre-edge) store.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_steps_nxt = r_steps;
    w_fail_nxt  = r_fail;
    w_prev_cur  = f_lookup(r_prev_flat, r_cur);
    w_prev_nxt  = f_lookup(r_prev_flat, w_prev_cur);
    w_tgt_prev  = f_lookup(r_prev_flat, trace_target);
    w_tgt_ok    = ({1'b0, trace_target} < {1'b0, r_num_nodes}) && (w_tgt_prev != UNVISITED);
    w_last      = (w_prev_cur == r_cur);
    w_chain_end = (w_prev_nxt == UNVISITED)
                  || (({1'b0, r_steps} + {{INDEX_WIDTH{1'b0}}, 1'b1}) == {1'b0, r_num_nodes});
    case (r_state)
      ST_IDLE: begin
        if (trace_start) begin
          w_fail_nxt = 1'b0;
          if (w_tgt_ok) begin
            w_cur_nxt   = trace_target;
            w_steps_nxt = '0;
            w_state_nxt = ST_EMIT;
          end else begin
            w_fail_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (path_ready) begin
          if (w_last) begin
            w_state_nxt = ST_IDLE;
          end else if (w_chain_end) begin
            w_fail_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cur_nxt   = w_prev_cur;
            w_steps_nxt = r_steps + {{(INDEX_WIDTH-1){1'b0}}, 1'b1};
          end
        end else begin
          w_state_nxt = ST_EMIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Traceback state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cur   <= '0;
      r_steps <= '0;
      r_fail  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_steps <= w_steps_nxt;
      r_fail  <= w_fail_nxt;
    end
  end

  assign set_reject            = r_set_reject;
  assign unvisited_nodes       = r_unvisited;
  assign all_visited           = (r_unvisited == '0);
  assign prev_vector_flattened = r_prev_flat;
  assign trace_busy            = (r_state == ST_EMIT);
  assign path_valid            = (r_state == ST_EMIT);
  assign path_node             = r_cur;
  assign path_last             = (r_state == ST_EMIT) && w_last;
  assign trace_fail            = r_fail;

endmodule

// File: tb/tb_visited_path_store.sv
// Directed bench for visited_path_store: writes, rejects, traceback and reset.
module tb_visited_path_store;

  localparam int IW = 5;
  localparam int MN = 16;
  localparam int WP = 2;

  logic            clock;
  logic            reset;
  logic [IW-1:0]   number_of_nodes;
  logic [WP-1:0]   set_en;
  logic [IW*WP-1:0] set_index;
  logic [IW*WP-1:0] set_prev;
  logic [WP-1:0]   set_reject;
  logic [IW-1:0]   unvisited_nodes;
  logic            all_visited;
  logic [IW*MN-1:0] prev_vector_flattened;
  logic            trace_start;
  logic [IW-1:0]   trace_target;
  logic            trace_busy;
  logic            path_valid;
  logic            path_ready;
  logic [IW-1:0]   path_node;
  logic            path_last;
  logic            trace_fail;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  visited_path_store #(.MAX_NODES(MN), .INDEX_WIDTH(IW), .WRITE_PORTS(WP)) dut (
    .clock(clock), .reset(reset), .number_of_nodes(number_of_nodes),
    .set_en(set_en), .set_index(set_index), .set_prev(set_prev),
    .set_reject(set_reject), .unvisited_nodes(unvisited_nodes),
    .all_visited(all_visited), .prev_vector_flattened(prev_vector_flattened),
    .trace_start(trace_start), .trace_target(trace_target),
    .trace_busy(trace_busy), .path_valid(path_valid), .path_ready(path_ready),
    .path_node(path_node), .path_last(path_last), .trace_fail(trace_fail)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [IW-1:0] prev_of(input int j);
    return prev_vector_flattened[IW*j +: IW];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [1:0] en, input logic [IW-1:0] i0, input logic [IW-1:0] p0,
                          input logic [IW-1:0] i1, input logic [IW-1:0] p1);
    set_en    = en;
    set_index = {i1, i0};
    set_prev  = {p1, p0};
    step();
    set_en    = 2'b00;
  endtask

  task automatic do_reset(input logic [IW-1:0] n);
    reset           = 1'b1;
    number_of_nodes = n;
    step();
    reset           = 1'b0;
  endtask

  task automatic start_trace(input logic [IW-1:0] tgt);
    trace_target = tgt;
    trace_start  = 1'b1;
    step();
    trace_start  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(5'd10);
    for (int j = 0; j < MN; j++) begin
      chk_cnt++;
      if (prev_of(j) !== 5'd31) $display("FAIL reset_prev[%0d] got %0d exp 31", j, prev_of(j));
      else pass_cnt++;
    end
    chk_cnt++;
    if (unvisited_nodes !== 5'd10) $display("FAIL reset_unvisited got %0d exp 10", unvisited_nodes);
    else pass_cnt++;
    chk_cnt++;
    if ({all_visited, path_valid, trace_busy, trace_fail, path_last, set_reject} !== 6'b000000)
      $display("FAIL reset_flags got %b exp 000000",
               {all_visited, path_valid, trace_busy, trace_fail, path_last, set_reject});
    else pass_cnt++;
    chk_cnt++;
    if (path_node !== 5'd0) $display("FAIL reset_path_node got %0d exp 0", path_node);
    else pass_cnt++;
  endtask

  task automatic test_dual_write();
    do_write(2'b11, 5'd3, 5'd0, 5'd5, 5'd3);
    chk_cnt++;
    if ({prev_of(3), prev_of(5)} !== {5'd0, 5'd3})
      $display("FAIL dual_prev got %0d,%0d exp 0,3", prev_of(3), prev_of(5));
    else pass_cnt++;
    chk_cnt++;
    if (unvisited_nodes !== 5'd8) $display("FAIL dual_count got %0d exp 8", unvisited_nodes);
    else pass_cnt++;
    chk_cnt++;
    if (set_reject !== 2'b00) $display("FAIL dual_reject got %b exp 00", set_reject);
    else pass_cnt++;
    do_write(2'b11, 5'd4, 5'd1, 5'd4, 5'd2);
    chk_cnt++;
    if (prev_of(4) !== 5'd1) $display("FAIL collide_prev got %0d exp 1", prev_of(4));
    else pass_cnt++;
    chk_cnt++;
    if (set_reject !== 2'b10) $display("FAIL collide_reject got %b exp 10", set_reject);
    else pass_cnt++;
    chk_cnt++;
    if (unvisited_nodes !== 5'd7) $display("FAIL collide_count got %0d exp 7", unvisited_nodes);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (set_reject !== 2'b00) $display("FAIL reject_pulse got %b exp 00", set_reject);
    else pass_cnt++;
  endtask

  task automatic test_reject();
    do_write(2'b11, 5'd3, 5'd9, 5'd12, 5'd1);
    chk_cnt++;
    if (set_reject !== 2'b11) $display("FAIL rej_pulse got %b exp 11", set_reject);
    else pass_cnt++;
    chk_cnt++;
    if ({prev_of(3), prev_of(12)} !== {5'd0, 5'd31})
      $display("FAIL rej_prev got %0d,%0d exp 0,31", prev_of(3), prev_of(12));
    else pass_cnt++;
    chk_cnt++;
    if (unvisited_nodes !== 5'd7) $display("FAIL rej_count got %0d exp 7", unvisited_nodes);
    else pass_cnt++;
    do_write(2'bz0, 5'd6, 5'd0, 5'd6, 5'd0);
    chk_cnt++;
    if ({set_reject, prev_of(6), unvisited_nodes} !== {2'b00, 5'd31, 5'd7})
      $display("FAIL z_enable got %b,%0d,%0d exp 00,31,7", set_reject, prev_of(6), unvisited_nodes);
    else pass_cnt++;
  endtask

  task automatic test_trace_ready();
    logic [IW-1:0] exp_nodes [4];
    exp_nodes[0] = 5'd7; exp_nodes[1] = 5'd5; exp_nodes[2] = 5'd3; exp_nodes[3] = 5'd0;
    do_write(2'b11, 5'd0, 5'd0, 5'd7, 5'd5);
    chk_cnt++;
    if (unvisited_nodes !== 5'd5) $display("FAIL chain_count got %0d exp 5", unvisited_nodes);
    else pass_cnt++;
    path_ready = 1'b1;
    start_trace(5'd7);
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if ({path_valid, trace_busy, path_node, path_last} !== {1'b1, 1'b1, exp_nodes[i], (i == 3)})
        $display("FAIL trace_beat%0d got v=%b n=%0d l=%b exp v=1 n=%0d l=%b",
                 i, path_valid, path_node, path_last, exp_nodes[i], (i == 3));
      else pass_cnt++;
      step();
    end
    chk_cnt++;
    if ({path_valid, trace_busy, trace_fail} !== 3'b000)
      $display("FAIL trace_end got %b exp 000", {path_valid, trace_busy, trace_fail});
    else pass_cnt++;
  endtask

  task automatic test_trace_backpressure();
    logic [IW-1:0] exp_nodes [4];
    int beat;
    exp_nodes[0] = 5'd7; exp_nodes[1] = 5'd5; exp_nodes[2] = 5'd3; exp_nodes[3] = 5'd0;
    beat = 0;
    path_ready = 1'b0;
    start_trace(5'd7);
    for (int c = 0; c < 7; c++) begin
      path_ready = (c % 2 == 0);
      trace_start  = (c == 1);
      trace_target = 5'd3;
      chk_cnt++;
      if ({path_valid, path_node, path_last} !== {1'b1, exp_nodes[beat], (beat == 3)})
        $display("FAIL bp_cycle%0d got v=%b n=%0d l=%b exp v=1 n=%0d l=%b",
                 c, path_valid, path_node, path_last, exp_nodes[beat], (beat == 3));
      else pass_cnt++;
      step();
      trace_start = 1'b0;
      if (path_ready) beat++;
    end
    chk_cnt++;
    if ({path_valid, trace_fail} !== 2'b00)
      $display("FAIL bp_end got %b exp 00", {path_valid, trace_fail});
    else pass_cnt++;
    path_ready = 1'b1;
  endtask

  task automatic test_trace_fail();
    start_trace(5'd9);
    chk_cnt++;
    if ({trace_fail, path_valid, trace_busy} !== 3'b100)
      $display("FAIL unvisited_target got %b exp 100", {trace_fail, path_valid, trace_busy});
    else pass_cnt++;
    do_write(2'b01, 5'd8, 5'd2, 5'd0, 5'd0);
    start_trace(5'd8);
    chk_cnt++;
    if ({trace_fail, path_valid, path_node, path_last} !== {1'b0, 1'b1, 5'd8, 1'b0})
      $display("FAIL broken_beat got f=%b v=%b n=%0d l=%b exp f=0 v=1 n=8 l=0",
               trace_fail, path_valid, path_node, path_last);
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({trace_fail, path_valid} !== 2'b10)
      $display("FAIL broken_end got %b exp 10", {trace_fail, path_valid});
    else pass_cnt++;
    start_trace(5'd12);
    chk_cnt++;
    if ({trace_fail, path_valid} !== 2'b10)
      $display("FAIL range_target got %b exp 10", {trace_fail, path_valid});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_trace();
    path_ready = 1'b0;
    start_trace(5'd7);
    chk_cnt++;
    if ({path_valid, trace_fail} !== 2'b10)
      $display("FAIL mid_start got %b exp 10", {path_valid, trace_fail});
    else pass_cnt++;
    do_reset(5'd10);
    chk_cnt++;
    if ({path_valid, trace_busy, trace_fail} !== 3'b000)
      $display("FAIL mid_reset_flags got %b exp 000", {path_valid, trace_busy, trace_fail});
    else pass_cnt++;
    chk_cnt++;
    if ({unvisited_nodes, prev_of(0), prev_of(7)} !== {5'd10, 5'd31, 5'd31})
      $display("FAIL mid_reset_state got %0d,%0d,%0d exp 10,31,31",
               unvisited_nodes, prev_of(0), prev_of(7));
    else pass_cnt++;
    path_ready = 1'b1;
  endtask

  task automatic test_boundaries();
    do_reset(5'd0);
    chk_cnt++;
    if ({unvisited_nodes, all_visited} !== {5'd0, 1'b1})
      $display("FAIL zero_nodes got %0d,%b exp 0,1", unvisited_nodes, all_visited);
    else pass_cnt++;
    do_write(2'b01, 5'd0, 5'd0, 5'd0, 5'd0);
    chk_cnt++;
    if ({set_reject, prev_of(0), unvisited_nodes} !== {2'b01, 5'd31, 5'd0})
      $display("FAIL zero_write got %b,%0d,%0d exp 01,31,0", set_reject, prev_of(0), unvisited_nodes);
    else pass_cnt++;
    do_reset(5'd2);
    do_write(2'b11, 5'd0, 5'd0, 5'd1, 5'd0);
    chk_cnt++;
    if ({unvisited_nodes, all_visited, set_reject} !== {5'd0, 1'b1, 2'b00})
      $display("FAIL fill_all got %0d,%b,%b exp 0,1,00", unvisited_nodes, all_visited, set_reject);
    else pass_cnt++;
    do_write(2'b11, 5'd0, 5'd1, 5'd1, 5'd1);
    chk_cnt++;
    if ({unvisited_nodes, set_reject, prev_of(1)} !== {5'd0, 2'b11, 5'd0})
      $display("FAIL no_underflow got %0d,%b,%0d exp 0,11,0", unvisited_nodes, set_reject, prev_of(1));
    else pass_cnt++;
  endtask

  initial begin
    reset           = 1'b1;
    number_of_nodes = 5'd10;
    set_en          = 2'b00;
    set_index       = '0;
    set_prev        = '0;
    trace_start     = 1'b0;
    trace_target    = 5'd0;
    path_ready      = 1'b1;
    step();
    test_reset();
    test_dual_write();
    test_reject();
    test_trace_ready();
    test_trace_backpressure();
    test_trace_fail();
    test_reset_mid_trace();
    test_boundaries();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
